// File: rtl/ring_pkg.sv
// Shared types and helpers for consumers of the 4-bit one-hot ring counter bus.
package ring_pkg;

  localparam int MAXN = 32;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  // Rotate the low n bits of v left by one; bits at and above n are cleared.
  function automatic logic [MAXN-1:0] rotl1(input logic [MAXN-1:0] v, input int unsigned n);
    logic [MAXN-1:0] mask;
    mask = (MAXN'(1) << n) - MAXN'(1);
    return ((v << 1) | (v >> (n - 1))) & mask;
  endfunction

  function automatic logic is_onehot(input logic [MAXN-1:0] v);
    return (v != '0) && ((v & (v - MAXN'(1))) == '0);
  endfunction

endpackage

// File: rtl/ring_onehot_decode.sv
// Combinational one-hot legality check and binary encoder for a ring bus.
module ring_onehot_decode
  import ring_pkg::*;
#(
  parameter int N    = 4,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    code,
  output logic [IDXW-1:0] index,
  output logic            legal
);

  // NOTE: the default assignment ahead of the loop keeps this block latch-free.
  always_comb begin
    index = '0;
    for (int i = 0; i < N; i++) begin
      if (code[i]) index = IDXW'(i);
    end
    legal = is_onehot(MAXN'(code));
  end

endmodule

// File: rtl/ring_sequence_checker.sv
// Decodes a ring bus, locks onto the rotate-left sequence, and reports
// sequence errors and completed rotations.
module ring_sequence_checker
  import ring_pkg::*;
#(
  parameter int N        = 4,
  parameter int IDXW     = $clog2(N),
  parameter int LOCK_CNT = 2,
  parameter int CNTW     = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [N-1:0]    ring_in,
  output logic [IDXW-1:0] index,
  output logic            onehot_ok,
  output logic            locked,
  output logic            err,
  output logic [CNTW-1:0] err_count,
  output logic [CNTW-1:0] rev_count
);

  localparam int GW = $clog2(LOCK_CNT + 1);

  state_t          state;
  logic [N-1:0]    prev;
  logic [GW-1:0]   good;
  logic [IDXW-1:0] dec_index;
  logic            legal;
  logic [N-1:0]    expected;
  logic            match;
  logic            wrap;

  ring_onehot_decode #(.N(N), .IDXW(IDXW)) u_decode (
    .code  (ring_in),
    .index (dec_index),
    .legal (legal)
  );

  assign expected = N'(rotl1(MAXN'(prev), N));
  // legal is required because prev (and so expected) is zero straight out of reset.
  assign match    = legal && (ring_in == expected);
  assign wrap     = match && prev[N-1];

  // NOTE: sequential state uses non-blocking assignments only, so every branch
  // sees the pre-edge values of state, prev, good and the counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= UNLOCKED;
      prev      <= '0;
      good      <= '0;
      index     <= '0;
      onehot_ok <= 1'b0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
      rev_count <= '0;
    end else begin
      err <= 1'b0;
      if (en) begin
        if (legal) begin
          index     <= dec_index;
          onehot_ok <= 1'b1;
        end else begin
          onehot_ok <= 1'b0;
        end

        case (state)
          UNLOCKED: begin
            if (legal) begin
              prev  <= ring_in;
              good  <= '0;
              state <= ACQUIRE;
            end
          end
          ACQUIRE: begin
            if (match) begin
              prev <= ring_in;
              good <= good + GW'(1);
              if (int'(good) + 1 == LOCK_CNT) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else if (legal) begin
              prev <= ring_in;
              good <= '0;
            end else begin
              state <= UNLOCKED;
            end
          end
          LOCKED: begin
            if (match) begin
              prev <= ring_in;
              if (wrap) rev_count <= rev_count + CNTW'(1);
            end else begin
              err    <= 1'b1;
              locked <= 1'b0;
              if (err_count != '1) err_count <= err_count + CNTW'(1);
              if (legal) begin
                prev  <= ring_in;
                good  <= '0;
                state <= ACQUIRE;
              end else begin
                state <= UNLOCKED;
              end
            end
          end
          default: begin
            state  <= UNLOCKED;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ring_sequence_checker.sv
// Randomised and directed bench for ring_sequence_checker against a position-based
// reference model; two instances cover the 8-bit and 4-bit counter widths.
module tb_ring_sequence_checker;

  localparam int N        = 4;
  localparam int LOCK_CNT = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] ring_in;

  logic [1:0] index_a, index_b;
  logic       ok_a, ok_b, locked_a, locked_b, err_a, err_b;
  logic [7:0] errc_a, revc_a;
  logic [3:0] errc_b, revc_b;

  int checks = 0;
  int errors = 0;

  // Reference model: lock progress tracked as a position and a run length.
  int m_index, m_ok, m_locked, m_err, m_have, m_run, m_pos, errs, revs;

  always #5 clk = ~clk;

  ring_sequence_checker #(.N(N), .IDXW(2), .LOCK_CNT(LOCK_CNT), .CNTW(8)) dut (
    .clk(clk), .reset(reset), .en(en), .ring_in(ring_in),
    .index(index_a), .onehot_ok(ok_a), .locked(locked_a), .err(err_a),
    .err_count(errc_a), .rev_count(revc_a)
  );

  ring_sequence_checker #(.N(N), .IDXW(2), .LOCK_CNT(LOCK_CNT), .CNTW(4)) dut4 (
    .clk(clk), .reset(reset), .en(en), .ring_in(ring_in),
    .index(index_b), .onehot_ok(ok_b), .locked(locked_b), .err(err_b),
    .err_count(errc_b), .rev_count(revc_b)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_index = 0; m_ok = 0; m_locked = 0; m_err = 0;
    m_have = 0; m_run = 0; m_pos = 0; errs = 0; revs = 0;
  endtask

  task automatic model_step(input bit e, input logic [3:0] v);
    int  p;
    bit  legal, correct;
    m_err = 0;
    if (!e) return;
    legal = ($countones(v) == 1);
    p = 0;
    for (int i = 0; i < N; i++) if (v[i]) p = i;
    correct = legal && m_have && (p == (m_pos + 1) % N);
    if (legal) begin m_index = p; m_ok = 1; end
    else m_ok = 0;
    if (!m_have) begin
      if (legal) begin m_have = 1; m_run = 0; m_pos = p; end
    end else if (!m_locked) begin
      if (!legal) m_have = 0;
      else if (correct) begin
        m_run++;
        m_pos = p;
        if (m_run == LOCK_CNT) m_locked = 1;
      end else begin
        m_pos = p;
        m_run = 0;
      end
    end else begin
      if (correct) begin
        if (m_pos == N - 1) revs++;
        m_pos = p;
      end else begin
        m_err = 1;
        errs++;
        m_locked = 0;
        if (legal) begin m_pos = p; m_run = 0; end
        else m_have = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("index",      int'(index_a),  m_index);
    check("onehot_ok",  int'(ok_a),     m_ok);
    check("locked",     int'(locked_a), m_locked);
    check("err",        int'(err_a),    m_err);
    check("err_count",  int'(errc_a),   (errs > 255) ? 255 : errs);
    check("rev_count",  int'(revc_a),   revs % 256);
    check("locked4",    int'(locked_b), m_locked);
    check("err4",       int'(err_b),    m_err);
    check("err_count4", int'(errc_b),   (errs > 15) ? 15 : errs);
    check("rev_count4", int'(revc_b),   revs % 16);
  endtask

  task automatic feed(input bit e, input logic [3:0] v);
    @(negedge clk);
    en      = e;
    ring_in = v;
    @(posedge clk);
    model_step(e, v);
    #1;
    compare_all();
  endtask

  function automatic logic [3:0] next_code();
    return 4'(1 << ((m_pos + 1) % N));
  endfunction

  task automatic lock_up();
    repeat (LOCK_CNT + 2) feed(1'b1, next_code());
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] v;
    int         r;
    en      = 1'b0;
    ring_in = '0;
    reset   = 1'b0;
    #2;
    apply_reset();

    // Acquisition from reset and three full rotations.
    feed(1'b1, 4'b0001); feed(1'b1, 4'b0010);
    feed(1'b1, 4'b0100); feed(1'b1, 4'b1000);
    repeat (12) feed(1'b1, next_code());

    // Skipped code while locked, then relock.
    feed(1'b1, 4'b0100);
    feed(1'b1, 4'b1000); feed(1'b1, 4'b0001); feed(1'b1, 4'b0010);

    // Multi-hot and all-zero samples while locked.
    lock_up();
    feed(1'b1, 4'b0110);
    feed(1'b1, 4'b0000);

    // Pause with garbage on the bus, then resume with the right code.
    lock_up();
    while (m_pos != 1) feed(1'b1, next_code());
    repeat (5) feed(1'b0, 4'b1111);
    feed(1'b1, 4'b0100);
    feed(1'b1, next_code());

    // Seventeen wraps exercise rev_count wrap-around in the narrow instance.
    repeat (17 * N) feed(1'b1, next_code());

    // Twenty lock/error episodes drive the narrow err_count into saturation.
    repeat (20) begin
      lock_up();
      feed(1'b1, 4'b0101);
    end

    // Random mix of correct, wrong, illegal and idle samples.
    for (int k = 0; k < 800; k++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      feed(1'b1, next_code());
      else if (r < 80) feed(1'b1, 4'(1 << $urandom_range(0, N - 1)));
      else if (r < 90) feed(1'b1, 4'($urandom_range(0, 15)));
      else             feed(1'b0, 4'($urandom_range(0, 15)));
    end

    // Asynchronous reset between clock edges.
    lock_up();
    @(posedge clk);
    #3;
    apply_reset();
    lock_up();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
